xfire_pulse_gen_mc: RTL and testbench

//  - N-channel programmable pulse generator for the xfire digital top.
//  - Each channel emits delayed, width/period-programmable pulse trains.
//  - Modes: one-shot (single period) or continuous; independent start/stop per channel.
//  - Config is latched per channel at start; outputs are registered to drive analog/pad logic.

---
 rtl/xfire_pulse_gen_mc_pkg.sv | 27 ++
 rtl/xfire_pulse_gen_mc_ch.sv | 160 ++++++++++++++++
 rtl/xfire_pulse_gen_mc.sv | 49 ++++
 tb/tb_xfire_pulse_gen_mc.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xfire_pulse_gen_mc_pkg.sv
// xfire pulse generator: shared types and defaults.
// State/mode encodings and the per-channel output bundle.
package xfire_pulse_gen_mc_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } ch_state_e;

  typedef enum logic {
    MODE_ONESHOT = 1'b0,
    MODE_CONT    = 1'b1
  } ch_mode_e;

  typedef struct packed {
    logic pulse;
    logic busy;
    logic done;
    logic cfg_err;
  } ch_out_t;

endpackage

// File: rtl/xfire_pulse_gen_mc_ch.sv
// xfire pulse generator: one channel.
// Delay/high/low phase FSM with a shared down-counter.
module xfire_pulse_gen_mc_ch
  import xfire_pulse_gen_mc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             srst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_width,
  input  logic [CNT_W-1:0] cfg_period,
  output ch_out_t          o
);

  localparam logic [CNT_W-1:0] ONE = 1;

  ch_state_e        st_q, st_d;
  ch_mode_e         mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_q, w_d;
  logic [CNT_W-1:0] p_q, p_d;
  logic [CNT_W-1:0] w_in;
  logic             pend;
  logic             done_d;
  logic             err_d;
  ch_out_t          o_q;

  // High time is clipped to the period
  assign w_in = (cfg_width > cfg_period) ? cfg_period : cfg_width;

  always_comb begin
    st_d   = st_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    w_d    = w_q;
    p_d    = p_q;
    pend   = 1'b0;
    done_d = 1'b0;
    err_d  = 1'b0;
    if (stop) begin
      st_d = ST_IDLE;
    end else begin
      unique case (st_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_period == '0) begin
              err_d = 1'b1;
            end else begin
              mode_d = ch_mode_e'(mode);
              w_d    = w_in;
              p_d    = cfg_period;
              if (cfg_delay != '0) begin
                st_d  = ST_DELAY;
                cnt_d = cfg_delay - ONE;
              end else if (w_in != '0) begin
                st_d  = ST_HIGH;
                cnt_d = w_in - ONE;
              end else begin
                st_d  = ST_LOW;
                cnt_d = cfg_period - ONE;
              end
            end
          end
        end
        ST_DELAY: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else if (w_q != '0) begin
            st_d  = ST_HIGH;
            cnt_d = w_q - ONE;
          end else begin
            st_d  = ST_LOW;
            cnt_d = p_q - ONE;
          end
        end
        ST_HIGH: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else if (w_q != p_q) begin
            st_d  = ST_LOW;
            cnt_d = p_q - w_q - ONE;
          end else begin
            pend = 1'b1;
          end
        end
        ST_LOW: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else begin
            pend = 1'b1;
          end
        end
        default: st_d = ST_IDLE;
      endcase
      // End of period: rearm without a gap, or finish the one-shot
      if (pend) begin
        if (mode_q == MODE_CONT) begin
          if (w_q != '0) begin
            st_d  = ST_HIGH;
            cnt_d = w_q - ONE;
          end else begin
            st_d  = ST_LOW;
            cnt_d = p_q - ONE;
          end
        end else begin
          st_d   = ST_IDLE;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      st_q   <= ST_IDLE;
      mode_q <= MODE_ONESHOT;
      cnt_q  <= '0;
      w_q    <= '0;
      p_q    <= '0;
      o_q    <= '0;
    end else if (srst) begin
      st_q   <= ST_IDLE;
      mode_q <= MODE_ONESHOT;
      cnt_q  <= '0;
      w_q    <= '0;
      p_q    <= '0;
      o_q    <= '0;
    end else if (enable) begin
      st_q        <= st_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      w_q         <= w_d;
      p_q         <= p_d;
      o_q.pulse   <= (st_d == ST_HIGH);
      o_q.busy    <= (st_d != ST_IDLE);
      o_q.done    <= done_d;
      o_q.cfg_err <= err_d;
    end
  end

  assign o = o_q;

`ifdef RTL_DEBUG
  a_pulse_busy: assert property (@(posedge clk) disable iff (!arst_n)
    o_q.pulse |-> o_q.busy);
  a_done_idle: assert property (@(posedge clk) disable iff (!arst_n)
    !(o_q.done && o_q.busy));
  a_err_src: assert property (@(posedge clk) disable iff (!arst_n)
    (enable && !srst &&
     !(st_q == ST_IDLE && start && !stop && cfg_period == '0))
    |=> !o_q.cfg_err);
`endif

endmodule

// File: rtl/xfire_pulse_gen_mc.sv
// xfire pulse generator: N independent channels.
// Slices the packed config buses and gathers channel outputs.
module xfire_pulse_gen_mc
  import xfire_pulse_gen_mc_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  srst,
  input  logic                  enable,
  input  logic [N_CH-1:0]       start,
  input  logic [N_CH-1:0]       stop,
  input  logic [N_CH-1:0]       mode,
  input  logic [N_CH*CNT_W-1:0] cfg_delay,
  input  logic [N_CH*CNT_W-1:0] cfg_width,
  input  logic [N_CH*CNT_W-1:0] cfg_period,
  output logic [N_CH-1:0]       pulse_out,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH-1:0]       done,
  output logic [N_CH-1:0]       cfg_err
);

  ch_out_t ch_o [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    xfire_pulse_gen_mc_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .arst_n    (arst_n),
      .srst      (srst),
      .enable    (enable),
      .start     (start[i]),
      .stop      (stop[i]),
      .mode      (mode[i]),
      .cfg_delay (cfg_delay[i*CNT_W +: CNT_W]),
      .cfg_width (cfg_width[i*CNT_W +: CNT_W]),
      .cfg_period(cfg_period[i*CNT_W +: CNT_W]),
      .o         (ch_o[i])
    );
    assign pulse_out[i] = ch_o[i].pulse;
    assign busy[i]      = ch_o[i].busy;
    assign done[i]      = ch_o[i].done;
    assign cfg_err[i]   = ch_o[i].cfg_err;
  end

endmodule

// File: tb/tb_xfire_pulse_gen_mc.sv
// Bench for xfire_pulse_gen_mc: per-cycle scoreboard against a
// phase-arithmetic model, plus table vectors and corner sequences.
module tb_xfire_pulse_gen_mc;

  localparam int N  = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            arst_n, srst, enable;
  logic [N-1:0]    start, stop, mode;
  logic [N*CW-1:0] cfg_delay, cfg_width, cfg_period;
  logic [N-1:0]    pulse_out, busy, done, cfg_err;

  xfire_pulse_gen_mc #(.N_CH(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .srst      (srst),
    .enable    (enable),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .cfg_delay (cfg_delay),
    .cfg_width (cfg_width),
    .cfg_period(cfg_period),
    .pulse_out (pulse_out),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  typedef struct packed {
    logic [N-1:0] p;
    logic [N-1:0] b;
    logic [N-1:0] d;
    logic [N-1:0] e;
  } obs_t;

  typedef struct {
    int ch; bit md; int d; int w; int p;
    int busy_c; int high_c; int done_c; int err_c; int first_hi;
  } vec_t;

  obs_t sbq[$];
  obs_t got;
  int   n_chk = 0;
  int   n_fail = 0;

  // model: count of enabled edges since the accepted start
  int m_act[N], m_n[N], m_d[N], m_w[N], m_p[N];
  int m_mode[N], m_done[N], m_err[N];

  task automatic model_edge(output obs_t r);
    int ph;
    r = '0;
    for (int c = 0; c < N; c++) begin
      if (!arst_n || srst) begin
        m_act[c] = 0; m_n[c] = 0; m_done[c] = 0; m_err[c] = 0;
      end else if (enable) begin
        m_done[c] = 0; m_err[c] = 0;
        if (m_act[c] != 0) begin
          if (stop[c]) m_act[c] = 0;
          else begin
            m_n[c]++;
            if (m_mode[c] == 0 && m_n[c] == m_d[c] + m_p[c] + 1) begin
              m_act[c] = 0; m_done[c] = 1;
            end
          end
        end else if (start[c] && !stop[c]) begin
          if (cfg_period[c*CW +: CW] == '0) m_err[c] = 1;
          else begin
            m_act[c]  = 1;
            m_n[c]    = 1;
            m_d[c]    = int'(cfg_delay[c*CW +: CW]);
            m_p[c]    = int'(cfg_period[c*CW +: CW]);
            m_w[c]    = int'(cfg_width[c*CW +: CW]);
            if (m_w[c] > m_p[c]) m_w[c] = m_p[c];
            m_mode[c] = int'(mode[c]);
          end
        end
      end
      ph = m_n[c] - 1 - m_d[c];
      if (m_act[c] != 0 && ph >= 0) r.p[c] = ((ph % m_p[c]) < m_w[c]);
      r.b[c] = (m_act[c] != 0);
      r.d[c] = (m_done[c] != 0);
      r.e[c] = (m_err[c] != 0);
    end
  endtask

  task automatic step();
    obs_t x;
    model_edge(x);
    sbq.push_back(x);
    @(posedge clk);
    #1;
    got = {pulse_out, busy, done, cfg_err};
    x = sbq.pop_front();
    n_chk++;
    if (got !== x) begin
      n_fail++;
      $display("FAIL cycle t=%0t got p=%b b=%b d=%b e=%b want p=%b b=%b d=%b e=%b",
               $time, got.p, got.b, got.d, got.e, x.p, x.b, x.d, x.e);
    end
  endtask

  task automatic chk(input string nm, input int g, input int x);
    n_chk++;
    if (g != x) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, g, x);
    end
  endtask

  task automatic set_cfg(input int c, input bit md, input int d,
                         input int w, input int p);
    mode[c] = md;
    cfg_delay[c*CW +: CW]  = CW'(d);
    cfg_width[c*CW +: CW]  = CW'(w);
    cfg_period[c*CW +: CW] = CW'(p);
  endtask

  task automatic run_ch(input int c, input int ns, output int bc,
                        output int hc, output int dc, output int ec,
                        output int fh);
    bc = 0; hc = 0; dc = 0; ec = 0; fh = -1;
    start[c] = 1'b1;
    for (int r = 0; r < ns; r++) begin
      step();
      start[c] = 1'b0;
      if (got.b[c]) bc++;
      if (got.p[c]) begin
        if (fh < 0) fh = r;
        hc++;
      end
      if (got.d[c]) dc++;
      if (got.e[c]) ec++;
    end
  endtask

  vec_t vt[6];

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int bc, hc, dc, ec, fh;
    int h0, h1, h3, d0, d2, d3, er;

    vt[0] = '{0, 1'b0, 3, 2, 5, 8, 2, 1, 0, 3};
    vt[1] = '{1, 1'b0, 0, 0, 4, 4, 0, 1, 0, -1};
    vt[2] = '{2, 1'b0, 0, 7, 4, 4, 4, 1, 0, 0};
    vt[3] = '{3, 1'b0, 1, 0, 0, 0, 0, 0, 1, -1};
    vt[4] = '{0, 1'b0, 2, 3, 3, 5, 3, 1, 0, 2};
    vt[5] = '{1, 1'b0, 0, 1, 1, 1, 1, 1, 0, 0};

    for (int c = 0; c < N; c++) begin
      m_act[c] = 0; m_n[c] = 0; m_d[c] = 0; m_w[c] = 0;
      m_p[c] = 0; m_mode[c] = 0; m_done[c] = 0; m_err[c] = 0;
    end
    arst_n = 1'b0; srst = 1'b0; enable = 1'b1;
    start = '0; stop = '0; mode = '0;
    cfg_delay = '0; cfg_width = '0; cfg_period = '0;
    #2;
    step();
    step();
    chk("reset_outs", int'({pulse_out, busy, done, cfg_err}), 0);
    arst_n = 1'b1;
    step();
    step();

    // table vectors: single channel one-shots and boundaries
    foreach (vt[i]) begin
      set_cfg(vt[i].ch, vt[i].md, vt[i].d, vt[i].w, vt[i].p);
      run_ch(vt[i].ch, 40, bc, hc, dc, ec, fh);
      chk($sformatf("v%0d_busy", i), bc, vt[i].busy_c);
      chk($sformatf("v%0d_high", i), hc, vt[i].high_c);
      chk($sformatf("v%0d_done", i), dc, vt[i].done_c);
      chk($sformatf("v%0d_err", i), ec, vt[i].err_c);
      chk($sformatf("v%0d_first", i), fh, vt[i].first_hi);
    end

    // continuous 1,0,0 then stop mid-HIGH
    set_cfg(1, 1'b1, 0, 1, 3);
    run_ch(1, 13, bc, hc, dc, ec, fh);
    chk("cont_highs", hc, 5);
    chk("cont_busy", bc, 13);
    chk("cont_hi_at_stop", int'(got.p[1]), 1);
    stop[1] = 1'b1;
    step();
    stop[1] = 1'b0;
    chk("stop_pulse", int'(got.p[1]), 0);
    chk("stop_busy", int'(got.b[1]), 0);
    dc = int'(got.d[1]);
    for (int r = 0; r < 3; r++) begin
      step();
      dc += int'(got.d[1]);
    end
    chk("stop_no_done", dc, 0);

    // all channels together, retrigger while busy
    set_cfg(0, 1'b0, 1, 2, 4);
    set_cfg(1, 1'b1, 0, 3, 5);
    set_cfg(2, 1'b0, 2, 0, 3);
    set_cfg(3, 1'b0, 3, 4, 4);
    h0 = 0; h1 = 0; h3 = 0; d0 = 0; d2 = 0; d3 = 0; er = 0;
    for (int r = 0; r < 15; r++) begin
      if (r == 3) begin
        set_cfg(0, 1'b1, 0, 1, 2);
        set_cfg(1, 1'b0, 2, 1, 2);
        set_cfg(2, 1'b0, 0, 1, 0);
        set_cfg(3, 1'b1, 0, 2, 9);
      end
      start = (r == 0 || r == 3 || r == 4) ? '1 : '0;
      step();
      h0 += int'(got.p[0]); h1 += int'(got.p[1]); h3 += int'(got.p[3]);
      d0 += int'(got.d[0]); d2 += int'(got.d[2]); d3 += int'(got.d[3]);
      for (int c = 0; c < N; c++) er += int'(got.e[c]);
    end
    chk("all_ch0_high", h0, 2);
    chk("all_ch1_high", h1, 9);
    chk("all_ch3_high", h3, 4);
    chk("all_dones", d0 + d2 + d3, 3);
    chk("retrig_no_err", er, 0);
    stop = '1;
    step();
    stop = '0;
    chk("all_stopped", int'(got.b), 0);

    // enable low mid-DELAY and mid-HIGH stretches by 5 each
    set_cfg(0, 1'b0, 4, 3, 6);
    bc = 0; hc = 0; dc = -1; fh = -1;
    for (int r = 0; r < 25; r++) begin
      start[0] = (r == 0);
      enable = !((r >= 2 && r <= 6) || (r >= 11 && r <= 15));
      step();
      if (got.b[0]) bc++;
      if (got.p[0]) begin
        if (fh < 0) fh = r;
        hc++;
      end
      if (got.d[0] && dc < 0) dc = r;
    end
    enable = 1'b1;
    start = '0;
    chk("en_busy", bc, 20);
    chk("en_high", hc, 8);
    chk("en_first", fh, 9);
    chk("en_done_at", dc, 20);

    // async reset mid-HIGH
    set_cfg(2, 1'b0, 1, 4, 6);
    run_ch(2, 3, bc, hc, dc, ec, fh);
    chk("pre_arst_hi", int'(got.p[2]), 1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_async", int'({pulse_out, busy, done}), 0);
    step();
    arst_n = 1'b1;
    step();
    run_ch(2, 12, bc, hc, dc, ec, fh);
    chk("post_arst_busy", bc, 7);
    chk("post_arst_high", hc, 4);
    chk("post_arst_done", dc, 1);

    // sync reset mid-LOW, also while enable is low
    set_cfg(3, 1'b0, 0, 1, 5);
    run_ch(3, 3, bc, hc, dc, ec, fh);
    chk("pre_srst_busy", int'(got.b[3]), 1);
    srst = 1'b1;
    enable = 1'b0;
    step();
    srst = 1'b0;
    enable = 1'b1;
    chk("srst_outs", int'({pulse_out, busy, done}), 0);
    run_ch(3, 10, bc, hc, dc, ec, fh);
    chk("post_srst_busy", bc, 5);
    chk("post_srst_high", hc, 1);
    chk("post_srst_done", dc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
